// File: rtl/priority_scanner_pkg.sv
// Shared types and constants for the priority scanner.
package priority_scanner_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_e;

  localparam logic DIR_LSB = 1'b0;
  localparam logic DIR_MSB = 1'b1;

endpackage : priority_scanner_pkg

// File: rtl/priority_scanner_pick.sv
// Combinational picker: selects the lowest or highest set bit of a vector,
// returns it one-hot with its binary position, and flags empty / multi-bit.
module priority_pick
  import priority_scanner_pkg::*;
#(
  parameter  int unsigned WIDTH = 16,
  localparam int unsigned IDX_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] vector,
  input  logic             dir,
  output logic [WIDTH-1:0] onehot,
  output logic [IDX_W-1:0] idx,
  output logic             any,
  output logic             multi
);

  // Walk positions in scan order and keep the first set bit found.
  always_comb begin : pick
    logic             found;
    logic [IDX_W-1:0] pos;
    onehot = '0;
    idx    = '0;
    found  = 1'b0;
    pos    = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      pos = (dir == DIR_MSB) ? IDX_W'(int'(WIDTH) - 1 - i) : IDX_W'(i);
      if (!found && vector[pos]) begin
        found       = 1'b1;
        idx         = pos;
        onehot      = '0;
        onehot[pos] = 1'b1;
      end
    end
  end

  // Clearing the lowest set bit leaves something only if two or more were set.
  assign any   = |vector;
  assign multi = |(vector & (vector - WIDTH'(1)));

endmodule : priority_pick

// File: rtl/priority_scanner.sv
// Accepts a request word per handshake and emits each set bit as its own
// beat (one-hot + index), LSB-first or MSB-first, under consumer backpressure.
module priority_scanner
  import priority_scanner_pkg::*;
#(
  parameter  int unsigned WIDTH = 16,
  localparam int unsigned IDX_W = $clog2(WIDTH)
) (
  input  logic             clk_i,
  input  logic             srst_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             dir_i,
  input  logic             data_val_i,
  output logic             data_rdy_o,
  output logic [WIDTH-1:0] onehot_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             last_o,
  output logic             empty_o,
  output logic             val_o,
  input  logic             rdy_i
);

  state_e           state_q;
  logic [WIDTH-1:0] resid_q;
  logic             dir_q;

  logic [WIDTH-1:0] pick_onehot;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_any;
  logic             pick_multi;
  logic             scan;

  priority_pick #(.WIDTH(WIDTH)) u_pick (
    .vector (resid_q),
    .dir    (dir_q),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .any    (pick_any),
    .multi  (pick_multi)
  );

  // FSM with residual/direction registers; a beat handshake strips the picked bit.
  always_ff @(posedge clk_i or posedge srst_i) begin
    if (srst_i) begin
      state_q <= IDLE;
      resid_q <= '0;
      dir_q   <= DIR_LSB;
    end else begin
      case (state_q)
        IDLE: begin
          if (data_val_i) begin
            resid_q <= data_i;
            dir_q   <= dir_i;
            state_q <= SCAN;
          end
        end
        SCAN: begin
          if (rdy_i) begin
            resid_q <= resid_q & ~pick_onehot;
            if (!pick_multi) state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Beat outputs decode only registered state and are zero outside SCAN.
  assign scan       = (state_q == SCAN);
  assign val_o      = scan;
  assign data_rdy_o = (state_q == IDLE) & ~srst_i;
  assign onehot_o   = scan ? pick_onehot : '0;
  assign idx_o      = scan ? pick_idx : '0;
  assign last_o     = scan & ~pick_multi;
  assign empty_o    = scan & ~pick_any;

endmodule : priority_scanner

// File: tb/tb_priority_scanner.sv
// Self-checking bench for priority_scanner at WIDTH=8.
module tb_priority_scanner;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned IDX_W = 3;

  logic             clk_i = 1'b0;
  logic             srst_i;
  logic [WIDTH-1:0] data_i;
  logic             dir_i;
  logic             data_val_i;
  logic             data_rdy_o;
  logic [WIDTH-1:0] onehot_o;
  logic [IDX_W-1:0] idx_o;
  logic             last_o;
  logic             empty_o;
  logic             val_o;
  logic             rdy_i;

  int n_checks = 0;
  int n_fails  = 0;

  priority_scanner #(.WIDTH(WIDTH)) dut (
    .clk_i      (clk_i),
    .srst_i     (srst_i),
    .data_i     (data_i),
    .dir_i      (dir_i),
    .data_val_i (data_val_i),
    .data_rdy_o (data_rdy_o),
    .onehot_o   (onehot_o),
    .idx_o      (idx_o),
    .last_o     (last_o),
    .empty_o    (empty_o),
    .val_o      (val_o),
    .rdy_i      (rdy_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [7:0]  data;
    logic        dir;
    int          hold_first;
    int          n_beats;
    logic [63:0] beats;   // expected one-hot beats, beat 0 in the low byte
  } vec_t;

  logic [7:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] idx_of(input logic [7:0] oh);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 0; i < 8; i++) if (oh[i]) r = 3'(i);
    return r;
  endfunction

  // Reference: list every set bit in scan order; a zero word is one empty beat.
  task automatic model_word(input logic [7:0] d, input logic dr);
    exp_q.delete();
    for (int i = 0; i < 8; i++) begin
      int p;
      p = dr ? 7 - i : i;
      if (d[p]) exp_q.push_back(8'(1 << p));
    end
    if (d == 8'h00) exp_q.push_back(8'h00);
  endtask

  // Entry: at posedge+1 in an IDLE cycle. Exit: at posedge+1 in the next IDLE cycle.
  task automatic send_word(input logic [7:0] d, input logic dr, input int hold_first,
                           input int bp_pct, input bit noise);
    int   cycles;
    int   held;
    bit   hold;
    bit   first;
    chk("rdy_before_word", 64'(data_rdy_o), 64'd1);
    data_i = d; dir_i = dr; data_val_i = 1'b1;
    @(posedge clk_i); #1;
    cycles = 0; held = 0; first = 1'b1;
    while (exp_q.size() > 0 && cycles < 200) begin
      chk("val_in_scan", 64'(val_o), 64'd1);
      chk("rdy_in_scan", 64'(data_rdy_o), 64'd0);
      chk("onehot", 64'(onehot_o), 64'(exp_q[0]));
      chk("idx", 64'(idx_o), 64'(idx_of(exp_q[0])));
      chk("last", 64'(last_o), 64'(exp_q.size() == 1));
      chk("empty", 64'(empty_o), 64'(d == 8'h00));
      hold = (first && held < hold_first) || (bp_pct > 0 && $urandom_range(99) < bp_pct);
      if (hold) held++;
      rdy_i = !hold;
      if (!hold) begin
        void'(exp_q.pop_front());
        first = 1'b0;
      end
      data_val_i = (exp_q.size() > 0) && noise && ($urandom_range(1) == 1);
      data_i = 8'($urandom);
      dir_i  = 1'($urandom);
      @(posedge clk_i); #1;
      cycles++;
    end
    if (cycles >= 200) chk("beat_budget", 64'(cycles), 64'd0);
    rdy_i = 1'b0;
    data_val_i = 1'b0;
    chk("val_after_word", 64'(val_o), 64'd0);
    chk("rdy_after_word", 64'(data_rdy_o), 64'd1);
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = '{data: 8'hA4, dir: 1'b0, hold_first: 0, n_beats: 3, beats: 64'h0000_0000_0080_2004};
    vecs[1] = '{data: 8'hA4, dir: 1'b1, hold_first: 0, n_beats: 3, beats: 64'h0000_0000_0004_2080};
    vecs[2] = '{data: 8'h00, dir: 1'b0, hold_first: 0, n_beats: 1, beats: 64'h0000_0000_0000_0000};
    vecs[3] = '{data: 8'h12, dir: 1'b0, hold_first: 3, n_beats: 2, beats: 64'h0000_0000_0000_1002};
    vecs[4] = '{data: 8'hFF, dir: 1'b0, hold_first: 0, n_beats: 8, beats: 64'h8040_2010_0804_0201};
    vecs[5] = '{data: 8'h01, dir: 1'b0, hold_first: 0, n_beats: 1, beats: 64'h0000_0000_0000_0001};

    srst_i = 1'b1; data_i = 8'h00; dir_i = 1'b0; data_val_i = 1'b0; rdy_i = 1'b0;
    #12;
    chk("reset_val", 64'(val_o), 64'd0);
    chk("reset_rdy", 64'(data_rdy_o), 64'd0);
    chk("reset_onehot", 64'(onehot_o), 64'd0);
    chk("reset_idx", 64'(idx_o), 64'd0);
    chk("reset_last_empty", 64'({last_o, empty_o}), 64'd0);
    @(posedge clk_i); #1;
    srst_i = 1'b0;
    #1;
    chk("rdy_after_release", 64'(data_rdy_o), 64'd1);

    // Table vectors back-to-back (0xFF then 0x01 with a single IDLE cycle).
    foreach (vecs[v]) begin
      exp_q.delete();
      for (int b = 0; b < vecs[v].n_beats; b++) begin
        logic [63:0] tmp;
        tmp = vecs[v].beats >> (8 * b);
        exp_q.push_back(tmp[7:0]);
      end
      send_word(vecs[v].data, vecs[v].dir, vecs[v].hold_first, 0, 1'b0);
    end

    // Reset mid-word: first beat of 0x0F consumed, then srst_i drops the rest.
    data_i = 8'h0F; dir_i = 1'b0; data_val_i = 1'b1;
    @(posedge clk_i); #1;
    data_val_i = 1'b0;
    chk("rst_word_beat0", 64'(onehot_o), 64'h01);
    rdy_i = 1'b1;
    @(posedge clk_i); #1;
    chk("rst_word_beat1", 64'(onehot_o), 64'h02);
    srst_i = 1'b1;
    #1;
    chk("rst_async_val", 64'(val_o), 64'd0);
    chk("rst_async_rdy", 64'(data_rdy_o), 64'd0);
    chk("rst_async_onehot", 64'(onehot_o), 64'd0);
    #1;
    srst_i = 1'b0;
    #1;
    chk("rst_release_rdy", 64'(data_rdy_o), 64'd1);
    for (int c = 0; c < 4; c++) begin
      @(posedge clk_i); #1;
      chk("rst_no_stale_beats", 64'(val_o), 64'd0);
    end
    rdy_i = 1'b0;

    // Randomised words with backpressure and input noise during SCAN.
    for (int r = 0; r < 60; r++) begin
      logic [7:0] d;
      logic       dr;
      d  = 8'($urandom);
      if (r % 10 == 0) d = 8'h00;
      dr = 1'($urandom);
      model_word(d, dr);
      send_word(d, dr, 0, 30, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1);
  end

endmodule : tb_priority_scanner
